// File: rtl/fight_round_controller.sv
// Referee/sequencer for the two-player fight datapath: collects one action per player per turn,
// strobes them to the player blocks, scores KO / turn-limit outcomes and runs a best-of-N match.
module fight_round_controller #(
   parameter int MAX_TURNS   = 16,
   parameter int WINS_NEEDED = 2,
   parameter int MAX_ROUNDS  = 5,
   parameter int ACT_TIMEOUT = 255,
   parameter int SETTLE_CYC  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] act1,
   input  logic [2:0] act2,
   input  logic       act1_valid,
   input  logic       act2_valid,
   output logic       act1_ready,
   output logic       act2_ready,
   input  logic [1:0] health1,
   input  logic [1:0] health2,
   output logic       round_rst,
   output logic       step,
   output logic [2:0] step_act1,
   output logic [2:0] step_act2,
   output logic [7:0] turn,
   output logic [3:0] round_no,
   output logic [1:0] wins1,
   output logic [1:0] wins2,
   output logic       round_done,
   output logic [1:0] round_result,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int              TO_W        = $clog2(ACT_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST     = TO_W'(ACT_TIMEOUT - 1);
   localparam logic [2:0]      SETTLE_LAST = 3'(SETTLE_CYC - 1);
   localparam logic [7:0]      TURN_LIMIT  = 8'(MAX_TURNS);
   localparam logic [1:0]      WINS_GOAL   = 2'(WINS_NEEDED);
   localparam logic [3:0]      ROUND_LIMIT = 4'(MAX_ROUNDS);
   localparam logic [2:0]      ACT_AWAIT   = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE, S_R_INIT, S_COLLECT, S_STEP, S_SETTLE, S_CHECK, S_R_END, S_GAME_OVER
   } state_t;

   state_t          state_r;
   logic [2:0]      cap1_r;
   logic [2:0]      cap2_r;
   logic [TO_W-1:0] to_cnt_r;
   logic [2:0]      settle_cnt_r;

   logic       hs1_s, hs2_s, pend1_s, pend2_s, timeout_s, collect_done_s;
   logic [2:0] nxt_act1_s, nxt_act2_s;
   logic [1:0] outcome_s;
   logic [1:0] final_s;

   // Handshake bookkeeping; a player still pending is one whose ready is up with no valid.
   always_comb begin
      hs1_s          = act1_ready & act1_valid;
      hs2_s          = act2_ready & act2_valid;
      pend1_s        = act1_ready & ~act1_valid;
      pend2_s        = act2_ready & ~act2_valid;
      timeout_s      = (to_cnt_r == TO_LAST);
      collect_done_s = ~pend1_s & ~pend2_s;
      nxt_act1_s     = hs1_s ? act1 : cap1_r;
      nxt_act2_s     = hs2_s ? act2 : cap2_r;
   end

   // Round outcome from current health; turn already holds the just-completed turn count.
   always_comb begin
      outcome_s = 2'b00;
      if (health1 == 2'b00 && health2 == 2'b00) begin
         outcome_s = 2'b11;
      end else if (health1 == 2'b00) begin
         outcome_s = 2'b10;
      end else if (health2 == 2'b00) begin
         outcome_s = 2'b01;
      end else if (turn == TURN_LIMIT) begin
         if (health1 > health2) begin
            outcome_s = 2'b01;
         end else if (health1 < health2) begin
            outcome_s = 2'b10;
         end else begin
            outcome_s = 2'b11;
         end
      end else begin
         outcome_s = 2'b00;
      end
   end

   // Match winner when the round limit is reached without anyone hitting the win goal.
   always_comb begin
      final_s = 2'b11;
      if (wins1 > wins2) begin
         final_s = 2'b01;
      end else if (wins1 < wins2) begin
         final_s = 2'b10;
      end else begin
         final_s = 2'b11;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_IDLE;
         cap1_r       <= ACT_AWAIT;
         cap2_r       <= ACT_AWAIT;
         to_cnt_r     <= '0;
         settle_cnt_r <= 3'd0;
         act1_ready   <= 1'b0;
         act2_ready   <= 1'b0;
         round_rst    <= 1'b0;
         step         <= 1'b0;
         step_act1    <= 3'd0;
         step_act2    <= 3'd0;
         turn         <= 8'd0;
         round_no     <= 4'd0;
         wins1        <= 2'd0;
         wins2        <= 2'd0;
         round_done   <= 1'b0;
         round_result <= 2'b00;
         game_over    <= 1'b0;
         winner       <= 2'b00;
      end else begin
         round_rst  <= 1'b0;
         step       <= 1'b0;
         round_done <= 1'b0;
         case (state_r)
            S_IDLE, S_GAME_OVER: begin
               if (start) begin
                  state_r   <= S_R_INIT;
                  round_rst <= 1'b1;
                  turn      <= 8'd0;
                  wins1     <= 2'd0;
                  wins2     <= 2'd0;
                  round_no  <= 4'd0;
                  winner    <= 2'b00;
                  game_over <= 1'b0;
               end
            end
            S_R_INIT: begin
               state_r    <= S_COLLECT;
               act1_ready <= 1'b1;
               act2_ready <= 1'b1;
               cap1_r     <= ACT_AWAIT;
               cap2_r     <= ACT_AWAIT;
               to_cnt_r   <= '0;
            end
            S_COLLECT: begin
               // Uncaptured players fall back to the await preloaded into cap on entry.
               if (collect_done_s || timeout_s) begin
                  state_r    <= S_STEP;
                  step       <= 1'b1;
                  step_act1  <= nxt_act1_s;
                  step_act2  <= nxt_act2_s;
                  cap1_r     <= nxt_act1_s;
                  cap2_r     <= nxt_act2_s;
                  act1_ready <= 1'b0;
                  act2_ready <= 1'b0;
               end else begin
                  if (hs1_s) begin
                     cap1_r     <= act1;
                     act1_ready <= 1'b0;
                  end
                  if (hs2_s) begin
                     cap2_r     <= act2;
                     act2_ready <= 1'b0;
                  end
                  to_cnt_r <= to_cnt_r + 1'b1;
               end
            end
            S_STEP: begin
               state_r      <= S_SETTLE;
               settle_cnt_r <= 3'd0;
            end
            S_SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  state_r <= S_CHECK;
                  if (turn != 8'hFF) begin
                     turn <= turn + 8'd1;
                  end
               end else begin
                  settle_cnt_r <= settle_cnt_r + 3'd1;
               end
            end
            S_CHECK: begin
               if (outcome_s != 2'b00) begin
                  state_r      <= S_R_END;
                  round_done   <= 1'b1;
                  round_result <= outcome_s;
                  if (outcome_s == 2'b01 && wins1 != WINS_GOAL) begin
                     wins1 <= wins1 + 2'd1;
                  end
                  if (outcome_s == 2'b10 && wins2 != WINS_GOAL) begin
                     wins2 <= wins2 + 2'd1;
                  end
                  if (round_no != 4'hF) begin
                     round_no <= round_no + 4'd1;
                  end
               end else begin
                  state_r    <= S_COLLECT;
                  act1_ready <= 1'b1;
                  act2_ready <= 1'b1;
                  cap1_r     <= ACT_AWAIT;
                  cap2_r     <= ACT_AWAIT;
                  to_cnt_r   <= '0;
               end
            end
            S_R_END: begin
               if (wins1 == WINS_GOAL) begin
                  state_r   <= S_GAME_OVER;
                  game_over <= 1'b1;
                  winner    <= 2'b01;
               end else if (wins2 == WINS_GOAL) begin
                  state_r   <= S_GAME_OVER;
                  game_over <= 1'b1;
                  winner    <= 2'b10;
               end else if (round_no == ROUND_LIMIT) begin
                  state_r   <= S_GAME_OVER;
                  game_over <= 1'b1;
                  winner    <= final_s;
               end else begin
                  state_r   <= S_R_INIT;
                  round_rst <= 1'b1;
                  turn      <= 8'd0;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fight_round_controller.sv
// Scoreboard bench for fight_round_controller: expected step actions and round records are
// queued when a turn is driven and compared when the controller strobes step / round_done.
module tb_fight_round_controller;

   localparam int MAXT = 4;
   localparam int WN   = 2;
   localparam int MR   = 5;
   localparam int ATO  = 20;
   localparam int SC   = 2;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [2:0] act1, act2;
   logic       act1_valid, act2_valid, act1_ready, act2_ready;
   logic [1:0] health1, health2;
   logic       round_rst, step, round_done, game_over;
   logic [2:0] step_act1, step_act2;
   logic [7:0] turn;
   logic [3:0] round_no;
   logic [1:0] wins1, wins2, round_result, winner;
   logic [31:0] all_outs;

   int n_vec = 0;
   int n_err = 0;
   int rr_cnt = 0;
   int m_turn, m_w1, m_w2, m_rn;
   int lat;
   logic [5:0] step_q[$];
   logic [9:0] rnd_q[$];
   logic [5:0] e_step;
   logic [9:0] e_rnd;

   always #5 clk = ~clk;

   fight_round_controller #(
      .MAX_TURNS(MAXT), .WINS_NEEDED(WN), .MAX_ROUNDS(MR), .ACT_TIMEOUT(ATO), .SETTLE_CYC(SC)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .act1(act1), .act2(act2), .act1_valid(act1_valid), .act2_valid(act2_valid),
      .act1_ready(act1_ready), .act2_ready(act2_ready),
      .health1(health1), .health2(health2),
      .round_rst(round_rst), .step(step), .step_act1(step_act1), .step_act2(step_act2),
      .turn(turn), .round_no(round_no), .wins1(wins1), .wins2(wins2),
      .round_done(round_done), .round_result(round_result),
      .game_over(game_over), .winner(winner)
   );

   assign all_outs = {act1_ready, act2_ready, round_rst, step, step_act1, step_act2, turn,
                      round_no, wins1, wins2, round_done, round_result, game_over, winner};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] score(input logic [1:0] h1, input logic [1:0] h2, input int t);
      if (h1 == 2'b00 && h2 == 2'b00) return 2'b11;
      if (h1 == 2'b00) return 2'b10;
      if (h2 == 2'b00) return 2'b01;
      if (t == MAXT) return (h1 > h2) ? 2'b01 : ((h1 < h2) ? 2'b10 : 2'b11);
      return 2'b00;
   endfunction

   // Output side of the scoreboard.
   always @(negedge clk) begin
      if (round_rst) rr_cnt++;
      if (step) begin
         if (step_q.size() == 0) begin
            check("step_unexpected", 32'(1'b1), 32'(1'b0));
         end else begin
            e_step = step_q.pop_front();
            check("step_acts", 32'({step_act1, step_act2}), 32'(e_step));
         end
      end
      if (round_done) begin
         if (rnd_q.size() == 0) begin
            check("round_unexpected", 32'(1'b1), 32'(1'b0));
         end else begin
            e_rnd = rnd_q.pop_front();
            check("round_rec", 32'({round_result, wins1, wins2, round_no}), 32'(e_rnd));
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!(act1_ready || act2_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(n < 200), 32'(1'b1));
   endtask

   task automatic wait_round_done();
      int n = 0;
      while (!round_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("round_done_seen", 32'(round_done), 32'(1'b1));
   endtask

   task automatic start_match();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_turn = 0; m_w1 = 0; m_w2 = 0; m_rn = 0;
   endtask

   task automatic play_turn(input logic [2:0] a1, input logic [2:0] a2, input logic v1,
                            input logic v2, input logic [1:0] h1, input logic [1:0] h2,
                            output int lat_o);
      logic [1:0] r;
      wait_ready();
      health1 = h1; health2 = h2;
      act1 = a1; act2 = a2; act1_valid = v1; act2_valid = v2;
      step_q.push_back({v1 ? a1 : 3'b010, v2 ? a2 : 3'b010});
      m_turn++;
      r = score(h1, h2, m_turn);
      if (r != 2'b00) begin
         if (r == 2'b01) m_w1++;
         else if (r == 2'b10) m_w2++;
         if (m_rn < 15) m_rn++;
         rnd_q.push_back({r, 2'(m_w1), 2'(m_w2), 4'(m_rn)});
         m_turn = 0;
      end
      lat_o = 0;
      do begin
         @(negedge clk);
         lat_o++;
         if (lat_o == 1 && !step && (v1 != v2))
            check("ready_drop", 32'({act1_ready, act2_ready}), 32'({~v1, ~v2}));
      end while (!step && lat_o < 200);
      check("step_seen", 32'(step), 32'(1'b1));
      check("ready_in_step", 32'({act1_ready, act2_ready}), 32'(2'b00));
      act1_valid = 1'b0; act2_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; act1 = 3'd0; act2 = 3'd0;
      act1_valid = 1'b0; act2_valid = 1'b0; health1 = 2'b11; health2 = 2'b11;
      repeat (2) @(negedge clk);
      check("reset_outs", all_outs, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_outs", all_outs, 32'd0);

      // Turn 1: both actions in the same cycle, then watch turn advance.
      rr_cnt = 0;
      start_match();
      check("r_init_pulse", 32'({round_rst, turn}), 32'({1'b1, 8'd0}));
      play_turn(3'b000, 3'b001, 1'b1, 1'b1, 2'b11, 2'b11, lat);
      check("step_latency", 32'(lat), 32'(1));
      check("rr_once", 32'(rr_cnt), 32'(1));
      check("turn_at_step", 32'(turn), 32'(0));
      repeat (SC) @(negedge clk);
      check("turn_settling", 32'(turn), 32'(0));
      @(negedge clk);
      check("turn_inc", 32'(turn), 32'(1));

      // KO of player 2 ends round 1.
      play_turn(3'b011, 3'b100, 1'b1, 1'b1, 2'b11, 2'b00, lat);
      wait_round_done();
      @(negedge clk);
      check("r_init_after", 32'(round_rst), 32'(1'b1));

      // Round 2: player 2 times out on turn 1, then equal health at the turn limit.
      play_turn(3'b011, 3'b000, 1'b1, 1'b0, 2'b11, 2'b11, lat);
      check("timeout_latency", 32'(lat), 32'(ATO));
      play_turn(3'b100, 3'b111, 1'b1, 1'b1, 2'b01, 2'b01, lat);
      play_turn(3'b110, 3'b010, 1'b1, 1'b1, 2'b01, 2'b01, lat);
      play_turn(3'b101, 3'b001, 1'b1, 1'b1, 2'b01, 2'b01, lat);
      wait_round_done();

      // Round 3: player 1 ahead on health at the turn limit wins the match.
      for (int i = 0; i < MAXT; i++)
         play_turn(3'(i), 3'(7 - i), 1'b1, 1'b1, 2'b10, 2'b01, lat);
      wait_round_done();
      @(negedge clk);
      check("game_over_p1", 32'({game_over, winner}), 32'({1'b1, 2'b01}));

      // Restart from GAME_OVER clears the match.
      start_match();
      check("new_match_clear", 32'({game_over, winner, wins1, wins2, round_no, round_rst}),
            32'({1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 1'b1}));
      play_turn(3'b000, 3'b000, 1'b1, 1'b1, 2'b00, 2'b11, lat);
      wait_round_done();
      play_turn(3'b001, 3'b001, 1'b1, 1'b1, 2'b00, 2'b00, lat);
      wait_round_done();

      // Reset while settling.
      play_turn(3'b010, 3'b011, 1'b1, 1'b1, 2'b11, 2'b11, lat);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_settle", all_outs, 32'd0);
      rst = 1'b0;
      step_q.delete(); rnd_q.delete();
      @(negedge clk);
      check("idle_after_rst", all_outs, 32'd0);

      // Reset while collecting with both actions offered.
      start_match();
      wait_ready();
      act1_valid = 1'b1; act2_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      check("rst_collect", all_outs, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("no_pulse_after_rst", all_outs, 32'd0);
      act1_valid = 1'b0; act2_valid = 1'b0;

      // Five drawn rounds exhaust the round limit: match is a draw.
      start_match();
      for (int r = 0; r < MR; r++) begin
         play_turn(3'b000, 3'b001, 1'b1, 1'b1, 2'b00, 2'b00, lat);
         wait_round_done();
      end
      @(negedge clk);
      check("max_rounds_end", 32'({game_over, winner, round_no}), 32'({1'b1, 2'b11, 4'd5}));

      repeat (3) @(negedge clk);
      check("sb_drain", 32'(step_q.size() + rnd_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
